// File: rtl/tile_plot_sweeper.sv
// Sweeps one T x T tile out of the tile ROM and emits clipped per-pixel plot strobes.
// ROM data arrives one cycle after its address and is combined with the delayed row/col.
module tile_plot_sweeper #(
    parameter int unsigned TILE_LOG2      = 3,
    parameter int unsigned COORD_W        = 9,
    parameter int unsigned TILE_IDX_W     = 4,
    parameter int unsigned SCREEN_W       = 160,
    parameter int unsigned SCREEN_H       = 120,
    parameter bit          TRANSPARENT_EN = 1'b1
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              start,
    input  logic [COORD_W-1:0]                origin_x,
    input  logic [COORD_W-1:0]                origin_y,
    input  logic [TILE_IDX_W-1:0]             tile_id,
    output logic [TILE_IDX_W+2*TILE_LOG2-1:0] rom_addr,
    input  logic [2:0]                        rom_data,
    output logic [7:0]                        x,
    output logic [6:0]                        y,
    output logic [2:0]                        colour,
    output logic                              plot,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    localparam logic [TILE_LOG2-1:0] LastIdx = '1;
    localparam logic [COORD_W:0]     XLim    = SCREEN_W[COORD_W:0];
    localparam logic [COORD_W:0]     YLim    = SCREEN_H[COORD_W:0];

    state_e                  state_q, state_d;
    logic [TILE_LOG2-1:0]    row_q, row_d, col_q, col_d;
    logic [TILE_LOG2-1:0]    row_p_q, col_p_q;
    logic                    valid_p_q;
    logic [COORD_W-1:0]      ox_q, ox_d, oy_q, oy_d;
    logic [TILE_IDX_W-1:0]   tile_q, tile_d;
    logic [COORD_W:0]        sx, sy;
    logic                    in_x, in_y, opaque;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            tile_q    <= '0;
            row_p_q   <= '0;
            col_p_q   <= '0;
            valid_p_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            tile_q    <= tile_d;
            row_p_q   <= row_q;
            col_p_q   <= col_q;
            valid_p_q <= (state_q == StFetch);
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        tile_d  = tile_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    ox_d    = origin_x;
                    oy_d    = origin_y;
                    tile_d  = tile_id;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StFetch: begin
                col_d = col_q + 1'b1;
                if (col_q == LastIdx) begin
                    row_d = row_q + 1'b1;
                    if (row_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // One extra bit so off-screen sums stay distinguishable instead of wrapping.
    assign sx = {ox_q[COORD_W-1], ox_q} + {{(COORD_W+1-TILE_LOG2){1'b0}}, col_p_q};
    assign sy = {oy_q[COORD_W-1], oy_q} + {{(COORD_W+1-TILE_LOG2){1'b0}}, row_p_q};

    always_comb begin
        in_x   = ~sx[COORD_W] && (sx < XLim);
        in_y   = ~sy[COORD_W] && (sy < YLim);
        opaque = !TRANSPARENT_EN || (rom_data != 3'd0);
        plot   = valid_p_q && in_x && in_y && opaque;
        x      = valid_p_q ? sx[7:0] : 8'd0;
        y      = valid_p_q ? sy[6:0] : 7'd0;
        colour = valid_p_q ? rom_data : 3'd0;
    end

    assign rom_addr = {tile_q, row_q, col_q};
    assign busy     = (state_q == StFetch) || (state_q == StDrain);
    assign done     = (state_q == StDone);

endmodule

// File: doc/tile_plot_sweeper.md
Name: tile_plot_sweeper

Overview:
- Consumes the screen-relative tile origin produced by the add/sub stage (tile world position minus scroll offset, two's complement).
- Sweeps every pixel of one square tile and fetches each pixel's colour from the tile ROM.
- Emits per-pixel plot strobes to the VGA adapter and clips pixels that fall off-screen.
- Sits between the add/sub coordinate stage and the VGA adapter in the tile-draw path.

Parameters:
- TILE_LOG2, 3, log2 of the tile edge in pixels; the tile is T×T, T = 2^TILE_LOG2.
- COORD_W, 9, width of the signed origin inputs; must match the add/sub n.
- TILE_IDX_W, 4, width of the tile index.
- SCREEN_W, 160, visible columns.
- SCREEN_H, 120, visible rows.
- TRANSPARENT_EN, 1, when 1, colour 0 is never plotted.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  draw request; sampled only when state is IDLE.
- origin_x  in  COORD_W  signed screen x of the tile's top-left pixel; latched when start is accepted.
- origin_y  in  COORD_W  signed screen y of the tile's top-left pixel; latched when start is accepted.
- tile_id  in  TILE_IDX_W  tile to draw; latched when start is accepted.
- rom_addr  out  TILE_IDX_W+2*TILE_LOG2  tile ROM address = {tile_id, row, col}.
- rom_data  in  3  pixel colour; valid one cycle after rom_addr (synchronous ROM).
- x  out  8  plot x.
- y  out  7  plot y.
- colour  out  3  plot colour.
- plot  out  1  write strobe to the VGA adapter; one pixel per cycle.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset (async, resetn=0): state=IDLE; plot, busy and done drop to 0 immediately. x, y, colour, rom_addr and the row/col counters are 0. Any sweep in progress is abandoned with no further plots.
- States: IDLE → FETCH → DRAIN → DONE → IDLE.
- IDLE: when start=1 at edge t0, latch origin_x, origin_y and tile_id, clear row/col, and go to FETCH.
- FETCH, cycles t0+1 .. t0+T*T:
  - Drive rom_addr for pixel k = row*T+col; col increments each cycle and wraps to 0 with row+1.
  - After the edge where the final address is presented (row=col=T-1), go to DRAIN.
- DRAIN: one cycle to plot the last ROM return, then go to DONE.
- Pixel pipeline:
  - rom_data, together with the delayed col/row, registers into the output stage.
  - The plot for pixel k is valid in cycle t0+2+k.
  - Last plot is at t0+T*T+1.
- Coordinate arithmetic:
  - sx = sign-extended origin_x + col, computed in COORD_W+1 bits signed; sy is computed the same way.
  - No wrap-around: negative or oversized results are clipped, never truncated to a screen coordinate.
- Plot condition: 0 ≤ sx < SCREEN_W, 0 ≤ sy < SCREEN_H, and (TRANSPARENT_EN=0 or colour≠0).
  - Otherwise plot=0 for that cycle, and x/y/colour are don't-care.
  - When plot=1, x=sx[7:0] and y=sy[6:0].
- busy: 1 from t0+1 through t0+T*T+1 (FETCH and DRAIN); 0 in DONE and IDLE.
- done: 1 for exactly the cycle t0+T*T+2 (DONE state).
- start handling:
  - Ignored in FETCH, DRAIN and DONE; not queued.
  - The earliest next accept is the IDLE edge after DONE.
- Input changes: origin and tile_id changing during a sweep have no effect.
- Fully off-screen tile: the full sweep still runs with zero plots; done still pulses at the same cycle.
- Reset mid-sweep: outputs go low asynchronously. After resetn rises, the block is in IDLE and accepts start on the next edge.

Test Plan:
- T=8, tile_id=3, origin=(10,20), ROM returns colour 5 everywhere:
  - first rom_addr=192 at t0+1;
  - 64 plots, the first x=10,y=20 at t0+2 and the last x=17,y=27 at t0+65;
  - done at t0+66; busy low at t0+66.
- origin_x=-3 (9'h1FD), origin_y=0: columns 0-2 suppressed; 40 plots total, and every row starts at x=0.
- origin=(156,116): only sx 156..159 and sy 116..119 plotted; 16 plots; done timing unchanged.
- TRANSPARENT_EN=1, checkerboard ROM (0/5): 32 plots, all colour 5. With TRANSPARENT_EN=0: 64 plots.
- start held high throughout, plus a second start pulse at t0+10:
  - with start held, the second sweep begins at the IDLE edge after done;
  - the pulse at t0+10 is ignored, with no extra plots.
- Assert resetn=0 at pixel 20:
  - plot, busy and done go to 0 before the next edge;
  - no plots occur after that point;
  - after release, a new start sweeps all 64 pixels correctly.
